// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, and data-memory wait with timeout.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        memread_ex,
  input  logic        taken_ex,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [1:0]  fsm_state     // 0 RUN, 1 MEM_WAIT, 2 HALT
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic [7:0] wait_inc;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = memread_ex & (rd_ex != 5'd0) &
                     ((use_rs1_id & (rs1_id == rd_ex)) |
                      (use_rs2_id & (rs2_id == rd_ex)));

  // wait_cnt holds the length of the current stall episode, so the first
  // stalled cycle (still in RUN) counts as one.
  assign wait_inc  = (state == ST_MEM_WAIT) ? (wait_cnt + 8'd1) : 8'd1;
  assign fsm_state = state;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state    <= ST_RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          wait_cnt_next = wait_inc;
          state_next    = (wait_inc == TIMEOUT_LIM) ? ST_HALT : ST_MEM_WAIT;
        end else begin
          wait_cnt_next = 8'd0;
          state_next    = ST_RUN;
        end
      end
      ST_HALT: begin
        state_next    = ST_HALT;
        wait_cnt_next = wait_cnt;
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // A MEM_WAIT cycle without mem_stall resolves exactly like RUN, so any
  // branch flush or load-use bubble held during the freeze is applied here.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_timeout = 1'b0;
    if (!RSTn) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state == ST_HALT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      mem_timeout = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (taken_ex) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (!pc_write && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (ifid_flush && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max consecutive data-memory wait cycles before timeout (1..255).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RSTn  input  1  reset, synchronous, active-low.
REQ-004 use_rs1_id, use_rs2_id  input  1 each  ID instruction reads rs1/rs2.
REQ-005 rs1_id, rs2_id  input  5 each  ID source register indices.
REQ-006 rd_ex  input  5  EX destination register; memread_ex  input  1  EX instruction is a load.
REQ-007 taken_ex  input  1  branch taken or jump (JAL/JALR) resolved in EX.
REQ-008 dmem_req  input  1  MEM stage accesses data memory; dmem_ready  input  1  access completes this cycle.
REQ-009 pc_write, ifid_write, idex_write, exmem_write  output  1 each  stage register enables.
REQ-010 ifid_flush, idex_flush, memwb_flush  output  1 each  insert bubble into that stage register.
REQ-011 mem_timeout  output  1  sticky wait-timeout error.
REQ-012 stall_cycles, flush_count  output  32 each  performance counters (see Configuration).

Function
REQ-013 States RUN, MEM_WAIT, HALT, held in a registered state; outputs combinational from state and inputs.
REQ-014 mem_stall = dmem_req & ~dmem_ready; load_use = memread_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
REQ-015 Priority per cycle: HALT > mem_stall > taken_ex > load_use > normal advance.
REQ-016 Normal advance: all *_write=1, all *_flush=0.
REQ-017 mem_stall (RUN or MEM_WAIT): all *_write=0, memwb_flush=1, other flushes 0; next state MEM_WAIT.
REQ-018 taken_ex without mem_stall: all *_write=1, ifid_flush=1, idex_flush=1, memwb_flush=0; 2-instruction penalty.
REQ-019 load_use without mem_stall or taken_ex: pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1; exactly one bubble per load.
REQ-020 MEM_WAIT with dmem_ready=1: that cycle evaluated as RUN (REQ-016/018/019 apply); next state RUN.
REQ-021 Wait counter 8-bit, cleared on entry to RUN, incremented each MEM_WAIT cycle with mem_stall.
REQ-022 Counter reaching TIMEOUT_CYC while mem_stall: next state HALT, mem_timeout=1.
REQ-023 HALT: all *_write=0, all flushes 0, mem_timeout=1; left only by reset.
REQ-024 Frozen pipeline keeps taken_ex/load_use inputs stable; no flush or stall is latched or dropped across MEM_WAIT.
REQ-025 dmem_req=1 with dmem_ready=1 in RUN: no stall, zero added latency.

Reset
REQ-026 RSTn=0 at rising edge: state RUN, wait counter 0, mem_timeout 0, counters 0.
REQ-027 While RSTn=0: all *_write=0, all *_flush=1, mem_timeout=0.
REQ-028 Reset in MEM_WAIT or HALT aborts the wait; first cycle after release evaluates as RUN.

Configuration
REQ-029 Macro HAZ_PERF_CNT_EN defined: stall_cycles +1 each cycle with pc_write=0 outside reset; flush_count +1 each cycle ifid_flush=1 outside reset; both saturate at 0xFFFFFFFF.
REQ-030 HAZ_PERF_CNT_EN undefined: stall_cycles and flush_count tied to 0, no counter flops.

Verification
REQ-031 memread_ex=1, rd_ex=5, use_rs1_id=1, rs1_id=5 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; then normal.
REQ-032 Same as REQ-031 with rd_ex=0 -> no stall; all writes 1.
REQ-033 taken_ex=1 with simultaneous load_use -> ifid_flush=1, idex_flush=1, pc_write=1.
REQ-034 dmem_req=1, dmem_ready=0 for 3 cycles then 1 with taken_ex=1 -> 3 frozen cycles with memwb_flush=1, then flush cycle, state RUN.
REQ-035 dmem_req=1, dmem_ready=0 held, TIMEOUT_CYC=4 -> HALT with mem_timeout=1 after 4 stalled cycles; stays until RSTn=0 then RUN.
REQ-036 HAZ_PERF_CNT_EN defined, REQ-031 then REQ-033 -> stall_cycles=1, flush_count=1.
